// File: rtl/rx_sbinit_responder.sv
// Receive-side SBINIT responder: waits for the partner's done request, answers
// with one done response on the shared sideband port, then reports end or timeout.
module rx_sbinit_responder #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_SBINIT_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_tx_valid,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic                    o_SBINIT_end_rx,
  output logic                    o_timeout_error
);

  localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_RESP = SB_MSG_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]    CNT_LAST      = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DONE_REQ,
    ST_SEND_DONE_RESP,
    ST_END,
    ST_TIMEOUT
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
  logic                    sent, sent_nxt;
  logic [SB_MSG_WIDTH-1:0] msg_nxt;
  logic                    valid_nxt, end_nxt, timeout_nxt;

  logic timeout_hit, req_hit, launch, complete;

  // Counter never wraps, even if it were left running past the compare point.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign timeout_hit = (cnt == CNT_LAST);
  assign req_hit     = i_rx_msg_valid && (i_decoded_SB_msg == MSG_DONE_REQ);
  assign launch      = !o_valid_rx && !sent && !i_tx_valid;
  assign complete    = o_valid_rx && i_falling_edge_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_SBINIT_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:           state_nxt = ST_WAIT_DONE_REQ;
        ST_WAIT_DONE_REQ:  if (timeout_hit)  state_nxt = ST_TIMEOUT;
                           else if (req_hit) state_nxt = ST_SEND_DONE_RESP;
        ST_SEND_DONE_RESP: if (complete)         state_nxt = ST_END;
                           else if (timeout_hit) state_nxt = ST_TIMEOUT;
        ST_END:            state_nxt = ST_END;
        ST_TIMEOUT:        state_nxt = ST_TIMEOUT;
        default:           state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs follow the current state, so an abort clears them one edge after IDLE.
  always_comb begin
    cnt_nxt     = cnt;
    sent_nxt    = sent;
    msg_nxt     = o_encoded_SB_msg_rx;
    valid_nxt   = o_valid_rx;
    end_nxt     = o_SBINIT_end_rx;
    timeout_nxt = o_timeout_error;
    case (state)
      ST_IDLE: begin
        cnt_nxt     = '0;
        sent_nxt    = 1'b0;
        msg_nxt     = '0;
        valid_nxt   = 1'b0;
        end_nxt     = 1'b0;
        timeout_nxt = 1'b0;
      end
      ST_WAIT_DONE_REQ: begin
        if (i_SBINIT_en) begin
          cnt_nxt = sat_inc(cnt);
          if (timeout_hit) begin
            timeout_nxt = 1'b1;
            valid_nxt   = 1'b0;
          end else if (req_hit) begin
            sent_nxt = 1'b0;
          end
        end
      end
      ST_SEND_DONE_RESP: begin
        if (i_SBINIT_en) begin
          cnt_nxt = sat_inc(cnt);
          if (complete) begin
            valid_nxt = 1'b0;
            end_nxt   = 1'b1;
          end else if (timeout_hit) begin
            timeout_nxt = 1'b1;
            valid_nxt   = 1'b0;
          end else if (launch) begin
            // TX sequencer owns the port while i_tx_valid is high.
            valid_nxt = 1'b1;
            msg_nxt   = MSG_DONE_RESP;
            sent_nxt  = 1'b1;
          end
        end
      end
      ST_END: begin
        end_nxt = 1'b1;
      end
      ST_TIMEOUT: begin
        timeout_nxt = 1'b1;
        valid_nxt   = 1'b0;
      end
      default: begin
        cnt_nxt     = '0;
        sent_nxt    = 1'b0;
        msg_nxt     = '0;
        valid_nxt   = 1'b0;
        end_nxt     = 1'b0;
        timeout_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt                 <= '0;
      sent                <= 1'b0;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_SBINIT_end_rx     <= 1'b0;
      o_timeout_error     <= 1'b0;
    end else begin
      cnt                 <= cnt_nxt;
      sent                <= sent_nxt;
      o_encoded_SB_msg_rx <= msg_nxt;
      o_valid_rx          <= valid_nxt;
      o_SBINIT_end_rx     <= end_nxt;
      o_timeout_error     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rx_sbinit_responder.sv
// Directed bench for rx_sbinit_responder: per-cycle expectations queued as
// stimulus is driven and checked after each rising edge.
module tb_rx_sbinit_responder;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_SBINIT_en = 1'b0;
  logic       i_rx_msg_valid = 1'b0;
  logic [3:0] i_decoded_SB_msg = 4'd0;
  logic       i_tx_valid = 1'b0;
  logic       i_falling_edge_busy = 1'b0;
  logic [3:0] o_encoded_SB_msg_rx;
  logic       o_valid_rx;
  logic       o_SBINIT_end_rx;
  logic       o_timeout_error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       v;
    logic [3:0] m;
    logic       e;
    logic       t;
    string      tag;
  } exp_t;
  exp_t sb[$];

  rx_sbinit_responder #(
    .SB_MSG_WIDTH(4),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH(16)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_SBINIT_en(i_SBINIT_en),
    .i_rx_msg_valid(i_rx_msg_valid),
    .i_decoded_SB_msg(i_decoded_SB_msg),
    .i_tx_valid(i_tx_valid),
    .i_falling_edge_busy(i_falling_edge_busy),
    .o_encoded_SB_msg_rx(o_encoded_SB_msg_rx),
    .o_valid_rx(o_valid_rx),
    .o_SBINIT_end_rx(o_SBINIT_end_rx),
    .o_timeout_error(o_timeout_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic v, input logic [3:0] m, input logic e,
                          input logic t, input string tag);
    exp_t x;
    x.v = v; x.m = m; x.e = e; x.t = t; x.tag = tag;
    sb.push_back(x);
  endtask

  // Message code is only meaningful while valid is expected.
  task automatic check_out();
    exp_t x;
    logic [6:0] obs, req;
    x   = sb.pop_front();
    obs = {o_valid_rx, o_SBINIT_end_rx, o_timeout_error, (x.v ? o_encoded_SB_msg_rx : 4'd0)};
    req = {x.v, x.e, x.t, (x.v ? x.m : 4'd0)};
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s observed v/e/t/msg=%b required=%b", x.tag, obs, req);
    end
  endtask

  task automatic cyc(input logic en, input logic rxv, input logic [3:0] msg,
                     input logic txv, input logic busy, input logic chk,
                     input logic ev, input logic [3:0] em, input logic ee,
                     input logic et, input string tag);
    i_SBINIT_en         = en;
    i_rx_msg_valid      = rxv;
    i_decoded_SB_msg    = msg;
    i_tx_valid          = txv;
    i_falling_edge_busy = busy;
    if (chk) push_exp(ev, em, ee, et, tag);
    @(posedge i_clk);
    #1;
    if (chk) check_out();
  endtask

  task automatic abort(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, tag);
  endtask

  // Enable, done_req next cycle, response launched the cycle after, busy-fall ends it.
  task automatic nominal_short(input string tag);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, tag);
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, tag);
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, tag);
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, tag);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, tag);
  endtask

  task automatic run_timeout(input string tag);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, tag);
    for (int k = 1; k < 16; k++) cyc(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, tag);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, tag);
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, tag);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, tag);
  endtask

  initial begin
    #2;
    push_exp(0, 0, 0, 0, "reset");
    check_out();
    tests++;
    assert (o_encoded_SB_msg_rx === 4'd0) else begin
      fails++;
      $error("FAIL reset_msg observed=%0d required=0", o_encoded_SB_msg_rx);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Nominal: strobe on cycle 3, busy-fall 4 cycles after valid rises.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "nom_en");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "nom_wait");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "nom_req");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "nom_launch");
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "nom_hold_valid");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, "nom_complete");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 1, 0, "nom_end_hold");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, "nom_end_hold");
    abort("nom_abort");

    // Arbitration: TX owns the port for 5 cycles after the request.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "arb_en");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "arb_req");
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, "arb_blocked");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "arb_launch");
    cyc(1, 0, 0, 1, 0, 1, 1, 2, 0, 0, "arb_hold");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, "arb_complete");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, "arb_no_relaunch");
    abort("arb_abort");

    // Ignored traffic, then a second done_req after launch.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "ign_en");
    cyc(1, 1, 3, 0, 0, 1, 0, 0, 0, 0, "ign_msg3");
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "ign_msg0");
    cyc(1, 1, 2, 0, 0, 1, 0, 0, 0, 0, "ign_msg2");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "ign_quiet");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "ign_req");
    cyc(1, 1, 1, 0, 0, 1, 1, 2, 0, 0, "ign_launch_dupreq");
    cyc(1, 1, 1, 0, 0, 1, 1, 2, 0, 0, "ign_dupreq");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, "ign_complete");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 1, 0, "ign_no_second");
    abort("ign_abort");

    run_timeout("timeout");

    // Busy-fall on the edge the counter reaches TIMEOUT_CYCLES-1.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "race_en");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "race_req");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "race_launch");
    for (int k = 0; k < 13; k++) cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "race_hold");
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, "race_complete");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, "race_end_hold");
    abort("race_abort");

    // Abort while valid, then a fresh handshake.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "ab_en");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "ab_req");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "ab_launch");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "ab_hold");
    abort("ab_drop");
    nominal_short("ab_renom");
    abort("ab_renom_abort");

    // Asynchronous reset while valid.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_en");
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "rst_req");
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, "rst_launch");
    #1;
    i_rst_n = 1'b0;
    i_SBINIT_en = 1'b0;
    #1;
    push_exp(0, 0, 0, 0, "rst_async_clear");
    check_out();
    tests++;
    assert (o_encoded_SB_msg_rx === 4'd0) else begin
      fails++;
      $error("FAIL rst_async_msg observed=%0d required=0", o_encoded_SB_msg_rx);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    nominal_short("rst_renom");
    abort("rst_renom_abort");

    // Counter restarts from 0 after a partial run and abort.
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "restart_en");
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "restart_wait");
    abort("restart_abort");
    run_timeout("restart_timeout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_sbinit_responder.md
# rx_sbinit_responder

Receive-side responder for the sideband initialization (SBINIT) state of the link training state machine. It runs alongside the SBINIT transmit-side sequencer under the same LTSM enable. It waits for the partner's SBINIT done request and answers it with a single SBINIT done response on the shared sideband message port. It then reports completion to the LTSM, or flags a timeout if the handshake does not finish within a bounded window.

## Interface
Parameters:
- SB_MSG_WIDTH, 4: width of encoded/decoded sideband message codes.
- TIMEOUT_CYCLES, 8000: i_clk cycles allowed from entering WAIT_DONE_REQ to reaching END. Must be ≥2 and fit in CNT_WIDTH.
- CNT_WIDTH, 16: timeout counter width.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_SBINIT_en  input  1  LTSM enable for the SBINIT state. Low means abort and return to idle.
- i_rx_msg_valid  input  1  one-cycle strobe from the SB decoder: i_decoded_SB_msg holds a new partner message.
- i_decoded_SB_msg  input  SB_MSG_WIDTH  decoded partner message code.
- i_tx_valid  input  1  the TX-side sequencer currently owns the SB message port.
- i_falling_edge_busy  input  1  SB has finished serializing the message presented by this block.
- o_encoded_SB_msg_rx  output  SB_MSG_WIDTH  message code to encode. Reset value 0.
- o_valid_rx  output  1  this block presents a valid message to the SB. Reset value 0.
- o_SBINIT_end_rx  output  1  RX-side SBINIT complete, to the LTSM. Reset value 0.
- o_timeout_error  output  1  handshake timed out; sticky until the enable drops. Reset value 0.

## Operation
- Message codes:
  - done_req = 1
  - done_resp = 2
  - out_of_reset = 3
  - All other codes, and out_of_reset, are ignored by this block.
- States are IDLE, WAIT_DONE_REQ, SEND_DONE_RESP, END and TIMEOUT. There is one registered state register; all outputs are registered.
- Global rule: if i_SBINIT_en = 0 in any state, the next state is IDLE. This has the highest priority.
- IDLE:
  - All outputs and the counter are 0 on every edge spent in IDLE.
  - If i_SBINIT_en = 1, go to WAIT_DONE_REQ.
- WAIT_DONE_REQ:
  - Counter increments each cycle.
  - Priority order: timeout (counter == TIMEOUT_CYCLES-1) goes to TIMEOUT; otherwise (i_rx_msg_valid && msg == 1) goes to SEND_DONE_RESP; otherwise stay.
- SEND_DONE_RESP:
  - Counter keeps incrementing. An internal flag `sent` is cleared on entry.
  - Launch: on an edge where o_valid_rx = 0, sent = 0 and i_tx_valid = 0, set o_valid_rx = 1, o_encoded_SB_msg_rx = 2 and sent = 1. While i_tx_valid = 1 the launch waits; this is port arbitration, and TX has priority.
  - Completion: on an edge where o_valid_rx = 1 and i_falling_edge_busy = 1, clear o_valid_rx, set o_SBINIT_end_rx = 1 and go to END.
  - Completion has priority over timeout. Timeout otherwise applies as in WAIT_DONE_REQ.
  - Further done_req strobes are ignored.
  - Exactly one response is sent per SBINIT entry.
- END:
  - o_SBINIT_end_rx is held at 1 and the counter is frozen.
  - Messages are ignored.
  - Leave only when the enable drops.
- TIMEOUT:
  - o_timeout_error = 1 and o_valid_rx = 0, set on the entering edge.
  - Held until the enable drops.
- Counter arithmetic: unsigned, never wraps. It is compared only against TIMEOUT_CYCLES-1, and it is held in END and TIMEOUT.

## Timing
- Enable to WAIT_DONE_REQ: 1 edge.
- done_req strobe sampled at edge E0: state becomes SEND_DONE_RESP after E0. If i_tx_valid = 0 in the following cycle, o_valid_rx = 1 and the message = 2 after E1. This gives 2-cycle latency from strobe to valid.
- Every cycle with i_tx_valid = 1 delays the launch by one cycle.
- i_falling_edge_busy sampled while o_valid_rx = 1 at edge Ek: after Ek, o_valid_rx = 0, o_SBINIT_end_rx = 1 and state = END, all on the same edge.
- i_falling_edge_busy while o_valid_rx = 0 has no effect.
- Timeout fires on the TIMEOUT_CYCLES-th edge after entering WAIT_DONE_REQ.
- Abort: enable low sampled at edge E gives state IDLE after E, and all outputs 0 after E+1.
- An asynchronous reset mid-handshake clears everything immediately.
- Re-enable after an abort restarts from WAIT_DONE_REQ with the counter at 0.

## Test plan
- Nominal: TIMEOUT_CYCLES = 16. Enable; strobe msg = 1 at cycle 3; keep i_tx_valid = 0; assert busy-fall 4 cycles after valid rises. Required: o_valid_rx = 1 with msg = 2 exactly 2 cycles after the strobe, then o_valid_rx = 0 and o_SBINIT_end_rx = 1 on the busy-fall edge, then held.
- Arbitration: i_tx_valid = 1 for 5 cycles after the done_req. Required: o_valid_rx stays 0 until the first cycle i_tx_valid = 0, and rises on the next edge. Exactly one launch.
- Ignored traffic: strobes with msg = 3, 0 and 2, then msg = 1. Required: no response until msg = 1. A second msg = 1 during SEND_DONE_RESP produces no second valid pulse.
- Timeout: TIMEOUT_CYCLES = 16, no done_req. Required: o_timeout_error = 1 after the 16th edge, and o_valid_rx stays 0. Enable low clears it one edge after IDLE.
- Completion beats timeout: busy-fall on the same edge the counter reaches 15. Required: END, o_SBINIT_end_rx = 1, o_timeout_error = 0.
- Abort/reset: drop the enable (then, on a separate run, pulse i_rst_n) while o_valid_rx = 1. Required: all outputs return to 0. Re-enable and a done_req complete the nominal sequence again.
